// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the RV32M multiply/divide sequencer.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      func_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            stall_o;
  logic [XLEN-1:0] result_o;
  logic            done_o;

  modport master (
    output start_i, func_i, op_a_i, op_b_i, flush_i,
    input  stall_o, result_o, done_o
  );

  modport slave (
    input  start_i, func_i, op_a_i, op_b_i, flush_i,
    output stall_o, result_o, done_o
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer sharing one shift/add-subtract engine.
// Optional single-cycle multiply path: define MULDIV_FAST_MUL_EN.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic         clk,
  input logic         rst,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         func_q, func_d;
  logic               neg_q, neg_d;
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               stall;

  // Operand conditioning for the incoming instruction
  logic               a_signed, b_signed, s_a, s_b, is_div, accept;
  logic [XLEN-1:0]    abs_a, abs_b;

  // Datapath intermediates
  logic [XLEN:0]      add_sum, mul_sum, shifted, diff;
  logic               ge;
  logic [2*XLEN-1:0]  prod_n;
  logic [XLEN-1:0]    quo_n, rem_n, fix_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb, fprod;
`endif

  always_comb begin
    a_signed = (bus.func_i == 3'd1) || (bus.func_i == 3'd2) ||
               (bus.func_i == 3'd4) || (bus.func_i == 3'd6);
    b_signed = (bus.func_i == 3'd1) || (bus.func_i == 3'd4) || (bus.func_i == 3'd6);
    s_a      = a_signed & bus.op_a_i[XLEN-1];
    s_b      = b_signed & bus.op_b_i[XLEN-1];
    abs_a    = s_a ? -bus.op_a_i : bus.op_a_i;
    abs_b    = s_b ? -bus.op_b_i : bus.op_b_i;
    is_div   = bus.func_i[2];
    accept   = bus.start_i & ~bus.flush_i;
  end

`ifdef MULDIV_FAST_MUL_EN
  always_comb begin
    fa    = signed'({{XLEN{s_a}}, bus.op_a_i});
    fb    = signed'({{XLEN{s_b}}, bus.op_b_i});
    fprod = fa * fb;
  end
`endif

  // Shift-add step: {carry, hi, lo} shifts right one place per iteration
  always_comb begin
    add_sum = {1'b0, hi_q} + {1'b0, b_q};
    mul_sum = lo_q[0] ? add_sum : {1'b0, hi_q};
    // Restoring step: shifted < 2*divisor, so a set top bit always means "subtract"
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    ge      = shifted[XLEN] | ~diff[XLEN];
  end

  always_comb begin
    prod_n = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_n  = neg_q ? -lo_q : lo_q;
    rem_n  = neg_q ? -hi_q : hi_q;
    if (!func_q[2]) begin
      fix_res = (func_q[1:0] == 2'd0) ? prod_n[XLEN-1:0] : prod_n[2*XLEN-1:XLEN];
    end else begin
      fix_res = func_q[1] ? rem_n : quo_n;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    func_d   = func_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    result_d = result_q;
    stall    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          stall   = 1'b1;
          func_d  = bus.func_i;
          neg_d   = (is_div && bus.func_i[1]) ? s_a : (s_a ^ s_b);
          cnt_d   = CNT_W'(XLEN - 1);
          hi_d    = '0;
          lo_d    = is_div ? abs_a : abs_b;
          b_d     = is_div ? abs_b : abs_a;
          state_d = StCalc;
          if (is_div && (bus.op_b_i == '0)) begin
            result_d = bus.func_i[1] ? bus.op_a_i : '1;
            state_d  = StDone;
          end else if (is_div && !bus.func_i[0] && (bus.op_a_i == IntMin) &&
                       (bus.op_b_i == '1)) begin
            result_d = bus.func_i[1] ? '0 : IntMin;
            state_d  = StDone;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            result_d = (bus.func_i[1:0] == 2'd0) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
            state_d  = StDone;
          end
`endif
        end
      end
      StCalc: begin
        stall = 1'b1;
        if (func_q[2]) begin
          hi_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        stall    = 1'b1;
        result_d = fix_res;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A killed operation leaves no trace on the result
    if (bus.flush_i) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      func_q   <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      func_q   <= func_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign bus.stall_o  = stall;
  assign bus.result_o = result_q;
  assign bus.done_o   = (state_q == StDone) & ~bus.flush_i;

endmodule
